// File: rtl/cpu_defs.sv
// Shared encodings and shadow-entry types for the ID-stage branch hazard logic.
package cpu_defs;

    localparam int unsigned REG_W = 5;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;

    localparam logic [1:0] JMP_REG = 2'b10;

    typedef struct packed {
        logic             v;
        logic             ld;
        logic [REG_W-1:0] rw;
    } shadow_t;

    typedef struct packed {
        logic a;
        logic b;
    } src_sel_t;

    // Which ID source registers a branch or register jump reads before it resolves.
    function automatic src_sel_t decode_srcs(
        input logic [2:0] br,
        input logic [1:0] jmp
    );
        src_sel_t s;
        s = '0;
        if (br == BR_BEQ || br == BR_BNE) begin
            s.a = 1'b1;
            s.b = 1'b1;
        end else if (br != BR_NONE) begin
            s.a = 1'b1;
        end else if (jmp == JMP_REG) begin
            s.a = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/hazard_shadow_entry.sv
// One in-flight writer slot: shifts in its predecessor each clock and
// reports whether it still holds a register an ID branch may not read yet.
module hazard_shadow_entry
    import cpu_defs::*;
#(
    parameter int unsigned POS        = 1,
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  shadow_t          shift_in,
    input  logic [REG_W-1:0] chk_a,
    input  logic [REG_W-1:0] chk_b,
    output shadow_t          ent,
    output logic             blk_a,
    output logic             blk_b
);

    localparam bit ALU_LIVE = (POS <= ALU_READY);
    localparam bit LD_LIVE  = (POS <= LOAD_READY);

    shadow_t ent_q;
    shadow_t ent_d;
    logic    live;

    always_comb begin
        ent_d = shift_in;
        if (reset) begin
            ent_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign live  = ent_q.v & (ent_q.ld ? LD_LIVE : ALU_LIVE);
    assign blk_a = live & (ent_q.rw == chk_a) & (chk_a != '0);
    assign blk_b = live & (ent_q.rw == chk_b) & (chk_b != '0);
    assign ent   = ent_q;

endmodule

// File: rtl/branch_hazard_scoreboard.sv
// ID-stage branch bubble generator backed by a shadow scoreboard of
// in-flight register writers, with a saturating stall-cycle counter.
module branch_hazard_scoreboard
    import cpu_defs::*;
#(
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned DEPTH      = LOAD_READY,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [REG_W-1:0] id_Ra,
    input  logic [REG_W-1:0] id_Rb,
    input  logic             id_RegWr,
    input  logic             id_MemtoReg,
    input  logic [REG_W-1:0] id_Rw,
    input  logic [2:0]       id_Branch,
    input  logic [1:0]       id_Jump,
    output logic             BranchBubble,
    output logic [CNT_W-1:0] stall_cnt
);

    shadow_t          head;
    shadow_t          ents [DEPTH];
    logic [DEPTH-1:0] blk_a;
    logic [DEPTH-1:0] blk_b;
    src_sel_t         src;
    logic             bubble;
    logic             unused_tail;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // A stalled or flushed ID slot must enter the shadow as a bubble.
    always_comb begin
        head.v  = id_valid & id_RegWr & (id_Rw != '0) & ~id_flush & ~bubble;
        head.ld = id_MemtoReg;
        head.rw = id_Rw;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_shadow
        shadow_t sin;
        if (k == 0) begin : g_head
            assign sin = head;
        end else begin : g_link
            assign sin = ents[k-1];
        end

        hazard_shadow_entry #(
            .POS        (k + 1),
            .ALU_READY  (ALU_READY),
            .LOAD_READY (LOAD_READY)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .shift_in (sin),
            .chk_a    (id_Ra),
            .chk_b    (id_Rb),
            .ent      (ents[k]),
            .blk_a    (blk_a[k]),
            .blk_b    (blk_b[k])
        );
    end

    assign unused_tail = ^ents[DEPTH-1];

    always_comb begin
        src    = decode_srcs(id_Branch, id_Jump);
        bubble = id_valid & ~reset & ~id_flush
               & ((src.a & (|blk_a)) | (src.b & (|blk_b)));
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
        end else if (bubble && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
    end

    assign BranchBubble = bubble;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// Directed scoreboard bench over four parameterisations sharing one ID stream.
module tb_branch_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic       id_flush;
    logic [4:0] id_Ra;
    logic [4:0] id_Rb;
    logic       id_RegWr;
    logic       id_MemtoReg;
    logic [4:0] id_Rw;
    logic [2:0] id_Branch;
    logic [1:0] id_Jump;

    logic        bb_def, bb_c2, bb_a0, bb_l3;
    logic [15:0] cnt_def, cnt_a0, cnt_l3;
    logic [1:0]  cnt_c2;

    int total = 0;
    int bad   = 0;

    string      tag_q[$];
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    branch_hazard_scoreboard u_def (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_RegWr(id_RegWr),
        .id_MemtoReg(id_MemtoReg), .id_Rw(id_Rw), .id_Branch(id_Branch),
        .id_Jump(id_Jump), .BranchBubble(bb_def), .stall_cnt(cnt_def)
    );

    branch_hazard_scoreboard #(.CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_RegWr(id_RegWr),
        .id_MemtoReg(id_MemtoReg), .id_Rw(id_Rw), .id_Branch(id_Branch),
        .id_Jump(id_Jump), .BranchBubble(bb_c2), .stall_cnt(cnt_c2)
    );

    branch_hazard_scoreboard #(.ALU_READY(0)) u_a0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_RegWr(id_RegWr),
        .id_MemtoReg(id_MemtoReg), .id_Rw(id_Rw), .id_Branch(id_Branch),
        .id_Jump(id_Jump), .BranchBubble(bb_a0), .stall_cnt(cnt_a0)
    );

    branch_hazard_scoreboard #(.LOAD_READY(3)) u_l3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_RegWr(id_RegWr),
        .id_MemtoReg(id_MemtoReg), .id_Rw(id_Rw), .id_Branch(id_Branch),
        .id_Jump(id_Jump), .BranchBubble(bb_l3), .stall_cnt(cnt_l3)
    );

    // Pops one expected bubble vector {def,c2,a0,l3} and compares it.
    task automatic check_bb();
        string      t;
        logic [3:0] e;
        logic [3:0] got;
        got = {bb_def, bb_c2, bb_a0, bb_l3};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL sb_empty got=%b exp=none", got);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (got === e) else begin
                bad++;
                $error("FAIL %s bubble got=%b exp=%b", t, got, e);
            end
        end
    endtask

    task automatic step(
        input string      tag,
        input logic       f,
        input logic       v,
        input logic [4:0] ra,
        input logic [4:0] rb,
        input logic       wr,
        input logic       ld,
        input logic [4:0] rw,
        input logic [2:0] br,
        input logic [1:0] jp,
        input logic [3:0] e
    );
        @(posedge clk);
        #1;
        reset       = 1'b0;
        id_flush    = f;
        id_valid    = v;
        id_Ra       = ra;
        id_Rb       = rb;
        id_RegWr    = wr;
        id_MemtoReg = ld;
        id_Rw       = rw;
        id_Branch   = br;
        id_Jump     = jp;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(negedge clk);
        check_bb();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            step("nop", 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 4'b0000);
        end
    endtask

    task automatic wrr(input string tag, input logic ld, input logic [4:0] rw,
                       input logic f);
        step(tag, f, 1, 0, 0, 1, ld, rw, 3'b000, 2'b00, 4'b0000);
    endtask

    task automatic brr(input string tag, input logic [2:0] br,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic f, input logic [3:0] e);
        step(tag, f, 1, ra, rb, 0, 0, 0, br, 2'b00, e);
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] e);
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, e);
        end
    endtask

    task automatic chk_cnt(input string tag, input int d, input int c2,
                           input int a0, input int l3);
        chk({tag, "_cnt_def"}, cnt_def, 16'(d));
        chk({tag, "_cnt_c2"}, {14'd0, cnt_c2}, 16'(c2));
        chk({tag, "_cnt_a0"}, cnt_a0, 16'(a0));
        chk({tag, "_cnt_l3"}, cnt_l3, 16'(l3));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        id_valid    = 1'b1;
        id_flush    = 1'b0;
        id_Ra       = 5'd3;
        id_Rb       = 5'd3;
        id_RegWr    = 1'b0;
        id_MemtoReg = 1'b0;
        id_Rw       = 5'd0;
        id_Branch   = 3'b001;
        id_Jump     = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tag_q.push_back("in_reset");
        exp_q.push_back(4'b0000);
        check_bb();
        chk_cnt("reset", 0, 0, 0, 0);

        // ALU writer in EX
        wrr("add3", 0, 5'd3, 0);
        brr("beq3_a", 3'b001, 5'd3, 5'd4, 0, 4'b1101);
        brr("beq3_b", 3'b001, 5'd3, 5'd4, 0, 4'b0000);
        nops(3);
        chk_cnt("alu", 1, 1, 0, 1);

        // load feeding BNE on rt
        wrr("lw5", 1, 5'd5, 0);
        brr("bne5_a", 3'b010, 5'd1, 5'd5, 0, 4'b1111);
        brr("bne5_b", 3'b010, 5'd1, 5'd5, 0, 4'b1111);
        brr("bne5_c", 3'b010, 5'd1, 5'd5, 0, 4'b0001);
        brr("bne5_d", 3'b010, 5'd1, 5'd5, 0, 4'b0000);
        nops(3);
        chk_cnt("load", 3, 3, 2, 4);

        // load, gap, then JR
        wrr("lw7", 1, 5'd7, 0);
        nops(1);
        step("jr7_a", 0, 1, 5'd7, 0, 0, 0, 0, 3'b000, 2'b10, 4'b1111);
        step("jr7_b", 0, 1, 5'd7, 0, 0, 0, 0, 3'b000, 2'b10, 4'b0001);
        step("jr7_c", 0, 1, 5'd7, 0, 0, 0, 0, 3'b000, 2'b10, 4'b0000);
        nops(3);
        chk_cnt("jr", 4, 3, 3, 6);

        // r0 never blocks; single-source branch ignores rt; non-JR jump
        wrr("add0", 0, 5'd0, 0);
        brr("beq00", 3'b001, 5'd0, 5'd0, 0, 4'b0000);
        wrr("add9", 0, 5'd9, 0);
        brr("bgez2", 3'b100, 5'd2, 5'd9, 0, 4'b0000);
        wrr("add6", 0, 5'd6, 0);
        brr("beq_rt6_a", 3'b001, 5'd1, 5'd6, 0, 4'b1101);
        brr("beq_rt6_b", 3'b001, 5'd1, 5'd6, 0, 4'b0000);
        wrr("add4", 0, 5'd4, 0);
        step("j4", 0, 1, 5'd4, 0, 0, 0, 0, 3'b000, 2'b01, 4'b0000);
        nops(3);
        chk_cnt("misc", 5, 3, 3, 7);

        // flush masks a hazard, and a flushed writer enters as a bubble
        wrr("add3f", 0, 5'd3, 0);
        brr("beq3_flush", 3'b001, 5'd3, 5'd3, 1, 4'b0000);
        wrr("add8_flush", 0, 5'd8, 1);
        brr("beq8", 3'b001, 5'd8, 5'd0, 0, 4'b0000);
        nops(3);
        chk_cnt("flush", 5, 3, 3, 7);

        // reset during the second load bubble
        wrr("lw5r", 1, 5'd5, 0);
        brr("bne5r_a", 3'b010, 5'd1, 5'd5, 0, 4'b1111);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tag_q.push_back("bne5r_rst");
        exp_q.push_back(4'b0000);
        @(negedge clk);
        check_bb();
        chk_cnt("prerst", 6, 3, 4, 8);
        brr("bne5r_after", 3'b010, 5'd1, 5'd5, 0, 4'b0000);
        chk_cnt("postrst", 0, 0, 0, 0);
        nops(3);

        // five default-config stalls against a 2-bit counter
        wrr("lw5s", 1, 5'd5, 0);
        brr("bne5s_a", 3'b010, 5'd1, 5'd5, 0, 4'b1111);
        brr("bne5s_b", 3'b010, 5'd1, 5'd5, 0, 4'b1111);
        brr("bne5s_c", 3'b010, 5'd1, 5'd5, 0, 4'b0001);
        nops(3);
        chk_cnt("sat1", 2, 2, 2, 3);
        wrr("add3s", 0, 5'd3, 0);
        brr("beq3s_a", 3'b001, 5'd3, 5'd4, 0, 4'b1101);
        brr("beq3s_b", 3'b001, 5'd3, 5'd4, 0, 4'b0000);
        nops(3);
        chk_cnt("sat2", 3, 3, 2, 4);
        wrr("lw5t", 1, 5'd5, 0);
        brr("bne5t_a", 3'b010, 5'd1, 5'd5, 0, 4'b1111);
        brr("bne5t_b", 3'b010, 5'd1, 5'd5, 0, 4'b1111);
        brr("bne5t_c", 3'b010, 5'd1, 5'd5, 0, 4'b0001);
        brr("bne5t_d", 3'b010, 5'd1, 5'd5, 0, 4'b0000);
        nops(3);
        chk_cnt("sat3", 5, 3, 4, 7);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_hazard_scoreboard.md
Name: branch_hazard_scoreboard

Overview:
- Parametrised successor of the ID-stage branch bubble logic.
- Keeps its own shadow scoreboard of in-flight register writers instead of taking per-stage ex/mem ports.
- Raises BranchBubble when an ID-stage branch, JR or JALR needs a register that is not yet forwardable to ID.
- Readiness stage is parametrised separately for ALU and load writers, and the block counts stall cycles.
- Sits beside the ID stage; drives the PC/IF-ID write-hold and the ID/EX bubble insert.

Parameters:
- ALU_READY, 1, last in-flight position (1=EX) at which an ALU writer still blocks an ID branch; 0 disables ALU stalls.
- LOAD_READY, 2, last in-flight position at which a load writer still blocks an ID branch; LOAD_READY >= ALU_READY, and LOAD_READY >= 1.
- DEPTH, LOAD_READY, number of shadow entries; must be >= LOAD_READY.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_flush  in  1  ID instruction is being killed (taken branch or jump); it enters the shadow as a bubble
- id_Ra  in  5  rs of the ID instruction
- id_Rb  in  5  rt of the ID instruction
- id_RegWr  in  1  ID instruction writes the register file
- id_MemtoReg  in  1  ID instruction is a load
- id_Rw  in  5  destination of the ID instruction
- id_Branch  in  3  000 none; 001 BEQ; 010 BNE; others BGEZ/BGTZ/BLEZ/BLTZ
- id_Jump  in  2  2'b10 = JR/JALR; any other value means no register jump
- BranchBubble  out  1  hold PC/IF-ID, insert a bubble into ID/EX
- stall_cnt  out  CNT_W  saturating count of BranchBubble cycles

Behaviour:
- Shadow entry k (1..DEPTH) holds {v, ld, rw}; entry 1 is the instruction currently in EX.
- Shift each clock:
  - entry k+1 <= entry k; entry DEPTH falls off.
  - entry 1 <= {id_valid & id_RegWr & (id_Rw!=0) & ~id_flush & ~BranchBubble, id_MemtoReg, id_Rw}.
  - A stalled or flushed ID therefore enters as an invalid bubble.
- Blocking: entry k blocks register r when v=1, rw==r, and k <= (ld ? LOAD_READY : ALU_READY). r==0 never blocks.
- Sources checked, by decoded type (id_Branch and id_Jump are mutually exclusive):
  - BEQ/BNE: id_Ra and id_Rb.
  - Other nonzero id_Branch: id_Ra only.
  - id_Branch==000 and id_Jump==2'b10: id_Ra only.
  - Anything else: no sources checked.
- BranchBubble = id_valid & ~reset & (any checked source blocked). It is combinational off the registered shadow and the ID inputs. 0 during reset.
- id_flush takes precedence: a flushed ID instruction never raises BranchBubble.
- stall_cnt increments when BranchBubble=1 and saturates at all-ones (no wrap).
- Reset:
  - clears all v bits and stall_cnt to 0.
  - mid-stall reset drops BranchBubble in the same cycle; the next cycle starts from an empty shadow.
- Defaults reproduce the legacy behaviour:
  - ALU writer in EX: 1 bubble.
  - Load in EX: 2 bubbles.
  - Load in MEM: 1 bubble.
- Simultaneous blocks on Ra and Rb: a single bubble per cycle. The stall repeats until both sources clear.
- Latency: no added latency on BranchBubble. The shadow updates 1 cycle after ID.

Decomposition:
- Shared package (cpu_defs): the BR_NONE/BR_BEQ/BR_BNE encodings, JMP_REG=2'b10, and REG_W=5.
- One sub-module, hazard_shadow_entry: a single {v, ld, rw} register with a shift-in mux and a block-compare output. It is instantiated DEPTH times.

Test Plan:
- add $3 then beq $3,$4 (ALU writer in EX): BranchBubble=1 for 1 cycle, then 0; stall_cnt=1.
- lw $5 then bne $1,$5: BranchBubble=1 for 2 consecutive cycles, then 0; stall_cnt=2.
- lw $7, then a nop, then jr $7: BranchBubble=1 for exactly 1 cycle.
- add $0 then beq $0,$0; also bgez $2 preceded by add $9: BranchBubble=0 in both cases.
- Reset pulse asserted during the second bubble of lw/bne: BranchBubble=0 that cycle, stall_cnt=0, shadow empty next cycle. Also check id_flush=1 with a hazard gives BranchBubble=0.
- CNT_W=2 with 5 forced stall cycles: stall_cnt saturates at 3. With ALU_READY=0: add then beq gives 0 bubbles. With LOAD_READY=3: lw-then-branch gives 3 bubbles.
